// File: rtl/codificador_input_param.sv
// Debounced N-key one-hot keypad encoder with single active-low load strobe per press,
// multi-key rejection and a parametrised 1 Hz tick divider.
module codificador_input_param #(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int TICK_DIV        = 100
) (
  input  logic              clk100Hz,
  input  logic              reset,
  input  logic              enablen,
  input  logic [N_KEYS-1:0] teclado,
  output logic [CODE_W-1:0] out_codificado,
  output logic              loadn,
  output logic              multi_key,
  output logic              pgt_1Hz
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(TICK_DIV - 1);
  localparam logic [N_KEYS-1:0] KEY_ONE = N_KEYS'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUALIFY,
    S_LOAD,
    S_HELD
  } state_t;

  state_t              state_q, state_d;
  logic [N_KEYS-1:0]   sample_q, sample_d;
  logic [CNT_W-1:0]    stab_q, stab_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                loadn_q, loadn_d;
  logic                multi_q, multi_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                pgt_q, pgt_d;

  logic [CODE_W-1:0]   key_idx;
  logic                one_hot;
  logic                stable;
  logic                sample_zero;

  // Downward scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    key_idx = '0;
    for (int unsigned i = N_KEYS; i > 0; i--) begin
      if (sample_q[i-1]) key_idx = CODE_W'(i - 1);
    end
  end

  always_comb begin
    sample_zero = (sample_q == '0);
    one_hot     = !sample_zero && ((sample_q & (sample_q - KEY_ONE)) == '0);
    stable      = (stab_q == CNT_MAX);
  end

  always_comb begin
    sample_d = teclado;
    state_d  = state_q;
    stab_d   = stab_q;
    code_d   = code_q;
    loadn_d  = 1'b1;
    multi_d  = multi_q;
    div_d    = div_q;
    pgt_d    = 1'b0;

    if (enablen) begin
      state_d = S_IDLE;
      stab_d  = '0;
      multi_d = 1'b0;
    end else begin
      // Count compares the incoming sample against the one currently held.
      if (teclado != sample_q) begin
        stab_d = '0;
      end else if (!stable) begin
        stab_d = stab_q + CNT_W'(1);
      end

      if (div_q == DIV_MAX) begin
        div_d = '0;
        pgt_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      unique case (state_q)
        S_IDLE: begin
          if (!sample_zero) state_d = S_QUALIFY;
        end
        S_QUALIFY: begin
          if (sample_zero) begin
            state_d = S_IDLE;
          end else if (stable) begin
            if (one_hot) begin
              state_d = S_LOAD;
              code_d  = key_idx;
              loadn_d = 1'b0;
            end else begin
              state_d = S_HELD;
              multi_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          state_d = S_HELD;
        end
        S_HELD: begin
          if (sample_zero && stable) begin
            state_d = S_IDLE;
            multi_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk100Hz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sample_q <= '0;
      stab_q   <= '0;
      code_q   <= '0;
      loadn_q  <= 1'b1;
      multi_q  <= 1'b0;
      div_q    <= '0;
      pgt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      stab_q   <= stab_d;
      code_q   <= code_d;
      loadn_q  <= loadn_d;
      multi_q  <= multi_d;
      div_q    <= div_d;
      pgt_q    <= pgt_d;
    end
  end

  assign out_codificado = code_q;
  assign loadn          = loadn_q;
  assign multi_key      = multi_q;
  assign pgt_1Hz        = pgt_q;

endmodule

// File: tb/tb_codificador_input_param.sv
// Directed and random checks of codificador_input_param against a history-based keypad model.
module tb_codificador_input_param;

  localparam int N  = 10;
  localparam int CW = 4;
  localparam int D  = 3;
  localparam int TD = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enablen = 1'b1;
  logic [N-1:0]  teclado = '0;
  logic [CW-1:0] out_codificado;
  logic          loadn;
  logic          multi_key;
  logic          pgt_1Hz;

  codificador_input_param #(
    .N_KEYS(N),
    .CODE_W(CW),
    .DEBOUNCE_CYCLES(D),
    .TICK_DIV(TD)
  ) dut (
    .clk100Hz(clk),
    .reset(reset),
    .enablen(enablen),
    .teclado(teclado),
    .out_codificado(out_codificado),
    .loadn(loadn),
    .multi_key(multi_key),
    .pgt_1Hz(pgt_1Hz)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef enum {M_IDLE, M_QUAL, M_LOAD, M_HELD} mphase_t;
  mphase_t       m_phase = M_IDLE;
  logic [N-1:0]  hist[$];
  int            en_cycles = 0;
  logic [CW-1:0] m_code = '0;
  logic          m_loadn = 1'b1;
  logic          m_multi = 1'b0;
  logic          m_pgt = 1'b0;

  int strobe_cyc[$];
  int strobe_code[$];
  int pulse_cyc[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Stable count = trailing run of identical samples minus one (history capped at D+1).
  function automatic int stable_count();
    int run = 1;
    for (int i = hist.size() - 2; i >= 0; i--) begin
      if (hist[i] == hist[hist.size()-1]) run++;
      else break;
    end
    return run - 1;
  endfunction

  task automatic model_edge(input logic rst, input logic en_n, input logic [N-1:0] key);
    logic [N-1:0] s;
    int c;
    if (rst) begin
      m_phase = M_IDLE; m_code = '0; m_loadn = 1'b1; m_multi = 1'b0; m_pgt = 1'b0;
      hist.delete(); hist.push_back('0); en_cycles = 0;
      return;
    end
    s = hist[hist.size()-1];
    c = stable_count();
    m_loadn = 1'b1;
    if (en_n) begin
      m_phase = M_IDLE; m_multi = 1'b0; m_pgt = 1'b0;
      hist.delete(); hist.push_back(key);
      return;
    end
    en_cycles++;
    m_pgt = ((en_cycles % TD) == 0);
    case (m_phase)
      M_IDLE: if (s != 0) m_phase = M_QUAL;
      M_QUAL: begin
        if (s == 0) m_phase = M_IDLE;
        else if (c == D) begin
          if ($countones(s) == 1) begin
            m_phase = M_LOAD; m_loadn = 1'b0; m_code = CW'($clog2(s));
          end else begin
            m_phase = M_HELD; m_multi = 1'b1;
          end
        end
      end
      M_LOAD: m_phase = M_HELD;
      M_HELD: if (s == 0 && c == D) begin m_phase = M_IDLE; m_multi = 1'b0; end
      default: m_phase = M_IDLE;
    endcase
    hist.push_back(key);
    while (hist.size() > D + 1) void'(hist.pop_front());
  endtask

  task automatic step(input logic rst, input logic en_n, input logic [N-1:0] key);
    reset = rst; enablen = en_n; teclado = key;
    @(posedge clk);
    cyc++;
    model_edge(rst, en_n, key);
    @(negedge clk);
    chk("loadn", int'(loadn), int'(m_loadn));
    chk("code", int'(out_codificado), int'(m_code));
    chk("multi_key", int'(multi_key), int'(m_multi));
    chk("pgt_1Hz", int'(pgt_1Hz), int'(m_pgt));
    if (loadn === 1'b0) begin strobe_cyc.push_back(cyc); strobe_code.push_back(int'(out_codificado)); end
    if (pgt_1Hz === 1'b1) pulse_cyc.push_back(cyc);
  endtask

  task automatic steps(input int n, input logic en_n, input logic [N-1:0] key);
    for (int i = 0; i < n; i++) step(1'b0, en_n, key);
  endtask

  task automatic clear_logs();
    strobe_cyc.delete(); strobe_code.delete(); pulse_cyc.delete();
  endtask

  initial begin
    int t0;
    logic [N-1:0] k;
    hist.push_back('0);

    // Reset state
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 10'h3FF);
    chk("rst_loadn", int'(loadn), 1);
    chk("rst_code", int'(out_codificado), 0);
    chk("rst_multi", int'(multi_key), 0);
    chk("rst_pgt", int'(pgt_1Hz), 0);
    steps(2, 1'b0, '0);

    // Single key 5
    clear_logs(); t0 = cyc;
    steps(10, 1'b0, 10'b0000100000);
    chk("single_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) begin
      chk("single_lat", strobe_cyc[0] - t0, 5);
      chk("single_code", strobe_code[0], 5);
    end
    steps(6, 1'b0, '0);

    // Bounce on key 3
    clear_logs();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 10'b0000001000 : '0);
    chk("bounce_none", strobe_cyc.size(), 0);
    t0 = cyc;
    steps(10, 1'b0, 10'b0000001000);
    chk("bounce_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) begin
      chk("bounce_lat", strobe_cyc[0] - t0, D + 2);
      chk("bounce_code", strobe_code[0], 3);
    end
    steps(6, 1'b0, '0);

    // Multi-key rejection
    clear_logs();
    steps(8, 1'b0, 10'b1000000001);
    chk("multi_set", int'(multi_key), 1);
    chk("multi_nostrobe", strobe_cyc.size(), 0);
    chk("multi_code_kept", int'(out_codificado), 3);
    steps(5, 1'b0, '0);
    chk("multi_clear", int'(multi_key), 0);
    steps(10, 1'b0, 10'b0010000000);
    chk("after_multi_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) chk("after_multi_code", strobe_code[0], 7);
    steps(6, 1'b0, '0);

    // Sweep 9..0
    clear_logs();
    for (int key = 9; key >= 0; key--) begin
      k = '0; k[key] = 1'b1;
      steps(20, 1'b0, k);
      steps(10, 1'b0, '0);
    end
    chk("sweep_count", strobe_code.size(), 10);
    for (int i = 0; i < strobe_code.size() && i < 10; i++) chk("sweep_code", strobe_code[i], 9 - i);

    // Key-to-key roll with no release
    clear_logs();
    steps(10, 1'b0, 10'b0000000100);
    steps(10, 1'b0, 10'b0000010000);
    chk("roll_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) chk("roll_code", strobe_code[0], 2);
    steps(6, 1'b0, '0);

    // Tick divider with enable hold-off
    step(1'b1, 1'b0, '0);
    clear_logs(); t0 = cyc;
    steps(350, 1'b0, '0);
    chk("tick_count", pulse_cyc.size(), 3);
    for (int i = 0; i < pulse_cyc.size() && i < 3; i++) chk("tick_at", pulse_cyc[i] - t0, 100 * (i + 1));
    steps(50, 1'b1, '0);
    steps(60, 1'b0, '0);
    chk("tick_delay_count", pulse_cyc.size(), 4);
    if (pulse_cyc.size() > 3) chk("tick_delayed", pulse_cyc[3] - t0, 450);

    // Reset during QUALIFY
    clear_logs();
    steps(2, 1'b0, 10'b0001000000);
    step(1'b1, 1'b0, 10'b0001000000);
    chk("rstq_loadn", int'(loadn), 1);
    chk("rstq_code", int'(out_codificado), 0);
    t0 = cyc;
    steps(10, 1'b0, 10'b0001000000);
    chk("rstq_count", strobe_cyc.size(), 1);
    if (strobe_cyc.size() > 0) begin
      chk("rstq_lat", strobe_cyc[0] - t0, 5);
      chk("rstq_code6", strobe_code[0], 6);
    end
    steps(6, 1'b0, '0);

    // Reset during LOAD
    clear_logs();
    steps(5, 1'b0, 10'b0000000010);
    chk("load_reached", int'(loadn), 0);
    step(1'b1, 1'b0, 10'b0000000010);
    chk("rstl_loadn", int'(loadn), 1);
    chk("rstl_code", int'(out_codificado), 0);
    steps(6, 1'b0, '0);

    // Randomised traffic against the model
    for (int n = 0; n < 250; n++) begin
      int sel;
      int hold;
      logic en_n;
      logic rst;
      sel = $urandom_range(0, 9);
      if (sel <= 2) k = '0;
      else if (sel <= 7) begin k = '0; k[$urandom_range(0, N - 1)] = 1'b1; end
      else k = N'($urandom);
      hold = $urandom_range(1, 8);
      en_n = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
      step(rst, en_n, k);
      steps(hold - 1, en_n, k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codificador_input_param.md
Name: codificador_input_param

Overview:
Parametrised successor to the microwave keypad encoder. Samples an N-key one-hot keypad on clk100Hz, debounces it, rejects multi-key presses and emits one binary key code with a single active-low load strobe per press. A press must be released before the next one is accepted. Also generates the 1 Hz countdown tick (pgt_1Hz) from a parametrised divider; both feed the time-register/controller datapath.

Parameters:
N_KEYS, 10, number of keypad lines; key i encodes to value i (0..N_KEYS-1)
CODE_W, 4, width of out_codificado; must satisfy 2**CODE_W >= N_KEYS
DEBOUNCE_CYCLES, 3, consecutive identical samples required to accept a press or release (>=1)
TICK_DIV, 100, clock cycles per pgt_1Hz pulse (>=2)

Ports:
clk100Hz  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enablen  in  1  active-low enable; 1 = keypad ignored and tick divider held
teclado  in  N_KEYS  raw keypad lines, bit i high = key i pressed
out_codificado  out  CODE_W  code of last accepted key, held until next accepted key
loadn  out  1  active-low one-cycle strobe; out_codificado valid in the same cycle
multi_key  out  1  high while a qualified multi-key sample is being held
pgt_1Hz  out  1  one-cycle high pulse every TICK_DIV enabled cycles

Behaviour:
- Reset (reset=1 at rising edge): state=IDLE, out_codificado=0, loadn=1, multi_key=0, pgt_1Hz=0, debounce count=0, divider count=0. Reset has priority over enablen. Reset mid-press discards the press; no strobe is issued.
- Input sampling: teclado is registered once (sample register, reset to 0). The FSM uses the sampled value only.
- Stability count: counts consecutive cycles with sample equal to the previous sample. It reloads to 0 on any change. It saturates at DEBOUNCE_CYCLES.
- FSM states:
  - IDLE: wait for a nonzero sample, then go to QUALIFY.
  - QUALIFY: if the sample returns to 0, go to IDLE. If stable for DEBOUNCE_CYCLES, check the bit count. Exactly one bit set: go to LOAD and capture that bit's index. More than one bit set: set multi_key=1 and go to HELD.
  - LOAD: exactly one cycle. loadn=0 and out_codificado=captured index, both registered. Then go to HELD.
  - HELD: wait for all-zero sample stable for DEBOUNCE_CYCLES, then clear multi_key and go to IDLE. Key changes while in HELD never produce a strobe (no auto-repeat, no roll-over).
- Latency: from the first cycle the key is present on teclado to loadn=0 is 1 (sample) + DEBOUNCE_CYCLES + 1 cycles. With defaults this is 5 cycles.
- enablen=1:
  - The FSM is forced to IDLE and the stability count clears.
  - loadn is held at 1 and multi_key is cleared.
  - out_codificado keeps its value.
  - The divider count freezes and pgt_1Hz=0.
  - A key held across enablen falling is treated as a new press.
- Divider: counts 0..TICK_DIV-1 while enablen=0. pgt_1Hz=1 (registered) in the cycle the count wraps from TICK_DIV-1 to 0. The first pulse comes exactly TICK_DIV enabled cycles after reset. The divider is independent of keypad activity.
- Width rules: index capture uses the lowest set bit (the one-hot case is guaranteed at LOAD), zero-extended to CODE_W. Divider width is clog2(TICK_DIV).
- Glitch shorter than DEBOUNCE_CYCLES during QUALIFY: the count restarts and no strobe is issued. A glitch to 0 shorter than DEBOUNCE_CYCLES during HELD does not release.

Test Plan:
- Single key: reset, enablen=0, teclado=10'b0000100000 held 10 cycles -> exactly one loadn=0 pulse, 5 cycles after the apply edge, out_codificado=5. No second pulse while held.
- Bounce: teclado toggles 0/bit3 every cycle for 6 cycles, then holds bit3 -> no strobe during bouncing. One strobe with code 3 at DEBOUNCE_CYCLES+2 cycles after the hold begins.
- Multi-key: teclado=10'b1000000001 held -> multi_key=1, no loadn pulse, out_codificado unchanged. After release to 0 for 3+ cycles, multi_key=0. A following key 7 press strobes code 7.
- Sweep: keys 9 down to 0 each held 20 cycles, 10 cycles of 0 between -> ten strobes with codes 9,8,...,0 in order. A direct key-to-key change with no release gives no strobe.
- Tick: enablen=0 for 350 cycles -> pgt_1Hz pulses at cycles 100, 200, 300. Setting enablen=1 for 50 cycles then 0 again delays the next pulse by 50 cycles.
- Reset mid-op: assert reset during QUALIFY and during LOAD -> loadn=1, out_codificado=0, divider restarts, next press behaves as fresh.
